// File: rtl/weight_skew_fifo.sv
// Row-wide weight buffer for the systolic PE array: circular buffer of rows with
// valid/ready writes, pop requests, tile-reuse loop mode and diagonally skewed output lanes.
module weight_skew_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int SKEW_EN    = 1,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] w_in [0:FIFO_WIDTH-1],
  input  logic                  rd_en,
  input  logic                  loop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] w_out [0:FIFO_WIDTH-1],
  output logic [FIFO_WIDTH-1:0] out_valid,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [0:FIFO_DEPTH-1][0:FIFO_WIDTH-1];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  wr_fire_s;
  logic                  pop_s;
  logic                  mem_we_s;

  // Depth need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  always_comb begin
    wr_ready  = !full_q && !loop && !flush;
    wr_fire_s = wr_valid && wr_ready;
    pop_s     = rd_en && !empty_q && !flush;
    mem_we_s  = wr_fire_s || (pop_s && loop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (mem_we_s) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      // A looped pop re-enqueues its row, so occupancy holds.
      case ({wr_fire_s, pop_s && !loop})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == {CW{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int j = 0; j < FIFO_WIDTH; j++) begin
        mem_q[wr_ptr_q][j] <= loop ? mem_q[rd_ptr_q][j] : w_in[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

  // Lane j owns a j+1 deep register chain (1 deep when unskewed); data is zeroed
  // whenever its valid is low so idle lanes present a harmless zero weight.
  for (genvar j = 0; j < FIFO_WIDTH; j++) begin : g_lane
    localparam int STAGES = (SKEW_EN != 0) ? j + 1 : 1;

    logic [DATA_WIDTH-1:0] dat_q [0:STAGES-1];
    logic [DATA_WIDTH-1:0] dat_d [0:STAGES-1];
    logic [STAGES-1:0]     vld_q, vld_d;

    always_comb begin
      dat_d = dat_q;
      vld_d = vld_q;
      if (flush) begin
        vld_d = {STAGES{1'b0}};
        for (int s = 0; s < STAGES; s++) begin
          dat_d[s] = {DATA_WIDTH{1'b0}};
        end
      end else begin
        vld_d[0] = pop_s;
        dat_d[0] = pop_s ? mem_q[rd_ptr_q][j] : {DATA_WIDTH{1'b0}};
        for (int s = 1; s < STAGES; s++) begin
          vld_d[s] = vld_q[s-1];
          dat_d[s] = dat_q[s-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q <= {STAGES{1'b0}};
        for (int s = 0; s < STAGES; s++) begin
          dat_q[s] <= {DATA_WIDTH{1'b0}};
        end
      end else begin
        vld_q <= vld_d;
        for (int s = 0; s < STAGES; s++) begin
          dat_q[s] <= dat_d[s];
        end
      end
    end

    assign w_out[j]     = dat_q[STAGES-1];
    assign out_valid[j] = vld_q[STAGES-1];
  end

endmodule

// File: tb/tb_weight_skew_fifo.sv
// Self-checking bench: a skewed and an unskewed instance share stimulus and are
// compared each cycle against a queue-based reference model plus directed vectors.
module tb_weight_skew_fifo;
  localparam int DW = 16;
  localparam int FW = 4;
  localparam int FD = 4;
  localparam int CB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, wr_valid, rd_en, loop, flush;
  logic [DW-1:0] w_in [0:FW-1];
  logic [DW-1:0] wo_a [0:FW-1];
  logic [DW-1:0] wo_b [0:FW-1];
  logic [FW-1:0] ov_a, ov_b;
  logic [CB-1:0] cnt_a, cnt_b;
  logic          full_a, full_b, empty_a, empty_b, rdy_a, rdy_b;
  logic [63:0]   wp_a, wp_b;

  assign wp_a = {wo_a[3], wo_a[2], wo_a[1], wo_a[0]};
  assign wp_b = {wo_b[3], wo_b[2], wo_b[1], wo_b[0]};

  weight_skew_fifo #(.DATA_WIDTH(DW), .FIFO_WIDTH(FW), .FIFO_DEPTH(FD), .SKEW_EN(1)) u_skew (
    .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(rdy_a), .w_in(w_in),
    .rd_en(rd_en), .loop(loop), .flush(flush), .w_out(wo_a), .out_valid(ov_a),
    .count(cnt_a), .full(full_a), .empty(empty_a));

  weight_skew_fifo #(.DATA_WIDTH(DW), .FIFO_WIDTH(FW), .FIFO_DEPTH(FD), .SKEW_EN(0)) u_flat (
    .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_ready(rdy_b), .w_in(w_in),
    .rd_en(rd_en), .loop(loop), .flush(flush), .w_out(wo_b), .out_valid(ov_b),
    .count(cnt_b), .full(full_b), .empty(empty_b));

  // Reference model: FIFO contents as a queue of rows, plus per-lane delivery schedules.
  logic [63:0] mq[$];
  bit          sv [0:1][0:3][0:3];
  logic [15:0] sd [0:1][0:3][0:3];
  logic [63:0] cur_row;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] col_q[$];
  bit          collect = 1'b0;
  int          maxcnt;
  bit          rdy_pre;
  logic [3:0]  seen23;

  typedef struct {
    bit          wv;
    bit          rd;
    int          k;
    bit          exp_rdy;
    int          exp_cnt;
    bit          exp_full;
    bit          exp_empty;
    logic [3:0]  exp_ov;
    logic [63:0] exp_w;
    logic [3:0]  exp_ov_flat;
    logic [63:0] exp_w_flat;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] row(input int k);
    logic [63:0] r;
    for (int j = 0; j < FW; j++) r[16*j +: 16] = 16'((k << 4) | j);
    return r;
  endfunction

  task automatic set_row(input logic [63:0] r);
    cur_row = r;
    for (int j = 0; j < FW; j++) w_in[j] = r[16*j +: 16];
  endtask

  task automatic model_reset();
    mq.delete();
    for (int m = 0; m < 2; m++)
      for (int j = 0; j < FW; j++)
        for (int k = 0; k < 4; k++) begin
          sv[m][j][k] = 1'b0;
          sd[m][j][k] = 16'h0;
        end
  endtask

  task automatic model_edge();
    bit          pop, wr;
    logic [63:0] head;
    pop = rd_en && (mq.size() > 0);
    wr  = wr_valid && (mq.size() < FD) && !loop;
    for (int m = 0; m < 2; m++)
      for (int j = 0; j < FW; j++) begin
        for (int k = 0; k < 3; k++) begin
          sv[m][j][k] = sv[m][j][k+1];
          sd[m][j][k] = sd[m][j][k+1];
        end
        sv[m][j][3] = 1'b0;
        sd[m][j][3] = 16'h0;
      end
    if (flush) begin
      model_reset();
    end else begin
      if (pop) begin
        head = mq.pop_front();
        if (loop) mq.push_back(head);
        for (int m = 0; m < 2; m++)
          for (int j = 0; j < FW; j++) begin
            sv[m][j][(m == 0) ? j : 0] = 1'b1;
            sd[m][j][(m == 0) ? j : 0] = head[16*j +: 16];
          end
      end
      if (wr) mq.push_back(cur_row);
    end
  endtask

  task automatic check_inst(input string tag, input int m, input logic [3:0] ov,
                            input logic [63:0] wp, input logic [CB-1:0] cnt,
                            input logic f, input logic e);
    logic [3:0]  ev;
    logic [63:0] ew;
    for (int j = 0; j < FW; j++) begin
      ev[j]         = sv[m][j][0];
      ew[16*j +: 16] = sv[m][j][0] ? sd[m][j][0] : 16'h0;
    end
    chk({tag, "_count"}, cnt, mq.size());
    chk({tag, "_full"}, f, mq.size() == FD);
    chk({tag, "_empty"}, e, mq.size() == 0);
    chk({tag, "_out_valid"}, ov, ev);
    chk({tag, "_w_out"}, wp, ew);
  endtask

  task automatic step();
    bit er;
    #1;
    er = (mq.size() < FD) && !loop && !flush;
    chk("skew_wr_ready", rdy_a, er);
    chk("flat_wr_ready", rdy_b, er);
    rdy_pre = rdy_a;
    @(posedge clk);
    model_edge();
    #1;
    check_inst("skew", 0, ov_a, wp_a, cnt_a, full_a, empty_a);
    check_inst("flat", 1, ov_b, wp_b, cnt_b, full_b, empty_b);
    if (collect && ov_a[0]) col_q.push_back(wo_a[0]);
    if (int'(cnt_a) > maxcnt) maxcnt = int'(cnt_a);
    seen23 |= ov_a;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; rd_en = 1'b0; loop = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs(); flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic write_rows(input int n);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1; set_row(row(k)); step();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 1, 1, 0, 0, 4'b0000, 64'h0, 4'b0000, 64'h0};
    tbl[1]  = '{1, 0, 1, 1, 2, 0, 0, 4'b0000, 64'h0, 4'b0000, 64'h0};
    tbl[2]  = '{1, 0, 2, 1, 3, 0, 0, 4'b0000, 64'h0, 4'b0000, 64'h0};
    tbl[3]  = '{1, 0, 3, 1, 4, 1, 0, 4'b0000, 64'h0, 4'b0000, 64'h0};
    tbl[4]  = '{1, 0, 4, 0, 4, 1, 0, 4'b0000, 64'h0, 4'b0000, 64'h0};
    tbl[5]  = '{1, 0, 4, 0, 4, 1, 0, 4'b0000, 64'h0, 4'b0000, 64'h0};
    tbl[6]  = '{1, 1, 4, 0, 3, 0, 0, 4'b0001, 64'h0,
                4'b1111, 64'h0003_0002_0001_0000};
    tbl[7]  = '{0, 0, 0, 1, 3, 0, 0, 4'b0010, 64'h0000_0000_0001_0000, 4'b0000, 64'h0};
    tbl[8]  = '{0, 0, 0, 1, 3, 0, 0, 4'b0100, 64'h0000_0002_0000_0000, 4'b0000, 64'h0};
    tbl[9]  = '{0, 0, 0, 1, 3, 0, 0, 4'b1000, 64'h0003_0000_0000_0000, 4'b0000, 64'h0};
    tbl[10] = '{0, 0, 0, 1, 3, 0, 0, 4'b0000, 64'h0, 4'b0000, 64'h0};

    rstn = 1'b0;
    idle_inputs();
    set_row(64'h0);
    model_reset();
    #12;
    chk("reset_count", cnt_a, 0);
    chk("reset_empty", empty_a, 1);
    chk("reset_full", full_a, 0);
    chk("reset_out_valid", {ov_b, ov_a}, 8'h00);
    chk("reset_w_out", wp_a | wp_b, 64'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Fill to full, blocked extra write, then pop and watch the skew diagonal.
    for (int i = 0; i < 11; i++) begin
      wr_valid = tbl[i].wv; rd_en = tbl[i].rd; set_row(row(tbl[i].k));
      step();
      chk("vec_wr_ready", rdy_pre, tbl[i].exp_rdy);
      chk("vec_count", cnt_a, tbl[i].exp_cnt);
      chk("vec_full", full_a, tbl[i].exp_full);
      chk("vec_empty", empty_a, tbl[i].exp_empty);
      chk("vec_out_valid", ov_a, tbl[i].exp_ov);
      chk("vec_w_out", wp_a, tbl[i].exp_w);
      chk("vec_flat_out_valid", ov_b, tbl[i].exp_ov_flat);
      chk("vec_flat_w_out", wp_b, tbl[i].exp_w_flat);
    end

    // Streaming with wrap: write 6 rows, popping from the second write onward.
    do_flush();
    col_q.delete(); maxcnt = 0; collect = 1'b1;
    wr_valid = 1'b1; set_row(row(0)); step();
    for (int k = 1; k < 6; k++) begin
      set_row(row(k)); rd_en = 1'b1; step();
    end
    wr_valid = 1'b0; step();
    rd_en = 1'b0;
    repeat (4) step();
    collect = 1'b0;
    chk("stream_maxcnt_le2", maxcnt <= 2, 1'b1);
    chk("stream_len", col_q.size(), 6);
    for (int k = 0; k < 6 && k < col_q.size(); k++) chk("stream_order", col_q[k], 16'(k << 4));

    // Loop reuse: three rows recirculated for nine pops, external write blocked.
    do_flush();
    write_rows(3);
    col_q.delete(); collect = 1'b1;
    loop = 1'b1; rd_en = 1'b1; wr_valid = 1'b1; set_row(row(7));
    for (int i = 0; i < 9; i++) begin
      step();
      chk("loop_wr_ready", rdy_pre, 1'b0);
    end
    idle_inputs();
    repeat (4) step();
    collect = 1'b0;
    chk("loop_count", cnt_a, 3);
    chk("loop_len", col_q.size(), 9);
    for (int k = 0; k < 9 && k < col_q.size(); k++) chk("loop_order", col_q[k], 16'((k % 3) << 4));

    // Empty edge: ignored pop, write+pop on empty, then a real pop.
    do_flush();
    rd_en = 1'b1; step();
    chk("empty_pop_valid", ov_a, 4'b0000);
    wr_valid = 1'b1; set_row(row(9)); step();
    chk("empty_wr_rd_count", cnt_a, 1);
    chk("empty_wr_rd_valid", ov_a, 4'b0000);
    wr_valid = 1'b0; step();
    chk("empty_then_pop_lane0", {ov_a[0], wo_a[0]}, {1'b1, 16'h0090});
    rd_en = 1'b0;
    repeat (4) step();

    // Flush right after a pop drops the in-flight row.
    do_flush();
    write_rows(2);
    rd_en = 1'b1; step();
    rd_en = 1'b0; flush = 1'b1; seen23 = 4'b0; step(); flush = 1'b0;
    chk("flush_valid_now", ov_a, 4'b0000);
    repeat (4) step();
    chk("flush_lanes23", seen23[3:2], 2'b00);
    chk("flush_count", cnt_a, 0);
    chk("flush_empty", empty_a, 1);

    // Asynchronous reset right after a pop.
    write_rows(2);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("areset_count", cnt_a, 0);
    chk("areset_empty", empty_a, 1);
    chk("areset_out_valid", {ov_b, ov_a}, 8'h00);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    seen23 = 4'b0;
    repeat (4) step();
    chk("areset_lanes23", seen23[3:2], 2'b00);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_en    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) loop = !loop;
      flush    = ($urandom_range(0, 29) == 0);
      set_row({$urandom, $urandom});
      step();
    end
    idle_inputs();
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
